// File: rtl/cva5_types.sv
// Shared types for the data-cache write buffer: one buffered write and the
// byte-merge used when a new write lands on the same word as the tail entry.
package cva5_types;

   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  wbe;
      logic [31:0] wdata;
      logic        rmw;
   } wb_entry_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                               input logic [31:0] new_data,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_data;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO with tail coalescing between the data cache master and the
// L2/bus arbiter; reads wait for the buffer to empty and then pass straight through.
module dcache_write_buffer
   import cva5_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        up_request,
   input  logic [29:0] up_addr,
   input  logic        up_rnw,
   input  logic [4:0]  up_rlen,
   input  logic [3:0]  up_wbe,
   input  logic [31:0] up_wdata,
   input  logic        up_rmw,
   output logic        up_ack,
   output logic        up_rvalid,
   output logic [31:0] up_rdata,
   output logic        write_outstanding,
   output logic        dn_request,
   output logic [29:0] dn_addr,
   output logic        dn_rnw,
   output logic [4:0]  dn_rlen,
   output logic [3:0]  dn_wbe,
   output logic [31:0] dn_wdata,
   output logic        dn_rmw,
   input  logic        dn_ack,
   input  logic        dn_rvalid,
   input  logic [31:0] dn_rdata,
   input  logic        dn_write_outstanding
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, READ_REQ, READ_DATA} state_t;

   state_t           state_q, state_d;
   wb_entry_t        entries_q [DEPTH];
   wb_entry_t        entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] last_idx;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       beats_q, beats_d;

   logic not_empty, full, read_issue, drain, hit, wr_req, wr_accept, push, pop;

   always_comb begin
      not_empty  = (count_q != '0);
      full       = (count_q == CNT_W'(DEPTH));
      last_idx   = tail_q - PTR_W'(1);
      // A read goes downstream only once every older write has left the buffer.
      read_issue = (state_q == READ_REQ) |
                   ((state_q == IDLE) & up_request & up_rnw & ~not_empty);
      drain      = not_empty & ~read_issue;
      // The head being offered downstream must not change under the arbiter.
      hit        = not_empty &
                   (entries_q[last_idx].addr == up_addr) &
                   (entries_q[last_idx].rmw == up_rmw) &
                   ~(drain & (last_idx == head_q));
      wr_req     = rst & up_request & ~up_rnw;
      wr_accept  = wr_req & (hit | ~full);
      push       = wr_accept & ~hit;
      pop        = drain & dn_ack;

      up_ack            = wr_accept | (rst & read_issue & dn_ack);
      up_rvalid         = rst & (state_q == READ_DATA) & dn_rvalid;
      up_rdata          = dn_rdata;
      write_outstanding = (rst & not_empty) | dn_write_outstanding;

      dn_request = rst & (read_issue | drain);
      dn_rnw     = read_issue;
      if (read_issue) begin
         dn_addr  = up_addr;
         dn_rlen  = up_rlen;
         dn_wbe   = '0;
         dn_wdata = '0;
         dn_rmw   = up_rmw;
      end else begin
         dn_addr  = entries_q[head_q].addr;
         dn_rlen  = '0;
         dn_wbe   = entries_q[head_q].wbe;
         dn_wdata = entries_q[head_q].wdata;
         dn_rmw   = entries_q[head_q].rmw;
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      state_d   = state_q;
      beats_d   = beats_q;

      if (wr_accept & hit) begin
         entries_d[last_idx].wbe   = entries_q[last_idx].wbe | up_wbe;
         entries_d[last_idx].wdata = merge_bytes(entries_q[last_idx].wdata, up_wdata, up_wbe);
      end
      if (push) begin
         entries_d[tail_q].addr  = up_addr;
         entries_d[tail_q].wbe   = up_wbe;
         entries_d[tail_q].wdata = up_wdata;
         entries_d[tail_q].rmw   = up_rmw;
         tail_d = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
         IDLE: begin
            if (read_issue) begin
               state_d = dn_ack ? READ_DATA : READ_REQ;
               if (dn_ack) beats_d = up_rlen;
            end
         end
         READ_REQ: begin
            if (dn_ack) begin
               state_d = READ_DATA;
               beats_d = up_rlen;
            end
         end
         READ_DATA: begin
            if (dn_rvalid) begin
               if (beats_q == '0) state_d = IDLE;
               else beats_d = beats_q - 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         beats_q <= beats_d;
      end
   end

   // Entry payload needs no reset: count_q gates every use of it.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule
